spi_cmd_receiver: RTL and testbench

SPI_CMD_RECEIVER -- requirements
Module: spi_cmd_receiver

---
 rtl/spi_cmd_receiver.sv | 193 +++++++++++++++++++
 tb/tb_spi_cmd_receiver.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_receiver.sv
// SPI command receiver: deserialises mode-0 SPI bytes into a small FIFO and
// replays each byte to the plane controller as a fixed-width dataEn pulse
// followed by a minimum idle gap.
module spi_cmd_receiver #(
  parameter int D_WIDTH    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int EN_CYCLES  = 8,
  parameter int GAP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               mosi,
  input  logic               csN,
  input  logic               dcIn,
  output logic [D_WIDTH-1:0] dataOut,
  output logic               dataEn,
  output logic               rs,
  output logic               overflow,
  output logic               fifoEmpty
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int BIT_W   = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam int MAX_CYC = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GAP
  } state_t;

  // Synchronizer bit order: {sck, mosi, csN, dcIn}
  logic [3:0]         r_sync_meta;
  logic [3:0]         r_sync;
  logic               r_sck_prev;
  logic [D_WIDTH-1:0] r_shift;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [D_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic               r_fifo_empty;
  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [D_WIDTH-1:0] r_data_out;
  logic               r_data_en;
  logic               r_rs;

  logic               w_sck;
  logic               w_mosi;
  logic               w_cs_n;
  logic               w_dc;
  logic               w_sck_rise;
  logic               w_byte_done;
  logic [D_WIDTH-1:0] w_byte;
  logic               w_pop;
  logic               w_wr_ok;
  logic [CNT_W-1:0]   w_count_next;
  logic [D_WIDTH:0]   w_rd_word;

  assign w_sck       = r_sync[3];
  assign w_mosi      = r_sync[2];
  assign w_cs_n      = r_sync[1];
  assign w_dc        = r_sync[0];
  assign w_sck_rise  = w_sck & ~r_sck_prev;
  assign w_byte      = {r_shift[D_WIDTH-2:0], w_mosi};
  assign w_byte_done = ~w_cs_n & w_sck_rise & (r_bit_cnt == BIT_W'(D_WIDTH - 1));
  assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign w_wr_ok     = w_byte_done && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop);
  assign w_rd_word   = r_mem[r_rd_ptr];

  // Two-flop synchronizers for all host pins plus the sck history bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sync_meta <= {sck, mosi, csN, dcIn};
      r_sync      <= r_sync_meta;
      r_sck_prev  <= r_sync[3];
    end
  end

  // Shift in MSB first; deselect abandons any partial byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_cs_n) begin
      r_bit_cnt <= '0;
    end else if (w_sck_rise) begin
      r_shift <= w_byte;
      if (r_bit_cnt == BIT_W'(D_WIDTH - 1)) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Next occupancy from the accepted write and the FSM pop
  always_comb begin
    w_count_next = r_count;
    case ({w_wr_ok, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage, no reset so it can map onto RAM
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= {w_dc, w_byte};
    end
  end

  // FIFO pointers, occupancy, empty flag and sticky drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_fifo_empty <= 1'b1;
      r_overflow   <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count      <= w_count_next;
      r_fifo_empty <= (w_count_next == '0);
      if (w_byte_done && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Output sequencer: pop, hold dataEn for EN_CYCLES, then idle GAP_CYCLES
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_data_out <= '0;
      r_data_en  <= 1'b0;
      r_rs       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_data_out <= w_rd_word[D_WIDTH-1:0];
            r_rs       <= w_rd_word[D_WIDTH];
            r_data_en  <= 1'b1;
            r_timer    <= TMR_W'(EN_CYCLES - 1);
            r_state    <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (r_timer == '0) begin
            r_data_en <= 1'b0;
            r_timer   <= TMR_W'(GAP_CYCLES - 1);
            r_state   <= ST_GAP;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_timer == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dataOut   = r_data_out;
  assign dataEn    = r_data_en;
  assign rs        = r_rs;
  assign overflow  = r_overflow;
  assign fifoEmpty = r_fifo_empty;

endmodule

// File: tb/tb_spi_cmd_receiver.sv
// Scoreboard bench for spi_cmd_receiver. The output gap is stretched so that
// a six-byte back-to-back burst at the fastest legal sck overruns the FIFO.
module tb_spi_cmd_receiver;

  localparam int DW     = 8;
  localparam int DEPTH  = 4;
  localparam int EN     = 8;
  localparam int GAP    = 256;
  localparam int PERIOD = EN + GAP + 1;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          sck   = 1'b0;
  logic          mosi  = 1'b0;
  logic          csN   = 1'b1;
  logic          dcIn  = 1'b0;
  logic [DW-1:0] dataOut;
  logic          dataEn;
  logic          rs;
  logic          overflow;
  logic          fifoEmpty;

  int            n_checks      = 0;
  int            n_errors      = 0;
  int            n_rises       = 0;
  int            cyc           = 0;
  int            last_rise_cyc = 0;
  bit            lat_armed     = 1'b0;
  logic [DW:0]   exp_q [$];

  spi_cmd_receiver #(
    .D_WIDTH   (DW),
    .FIFO_DEPTH(DEPTH),
    .EN_CYCLES (EN),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sck      (sck),
    .mosi     (mosi),
    .csN      (csN),
    .dcIn     (dcIn),
    .dataOut  (dataOut),
    .dataEn   (dataEn),
    .rs       (rs),
    .overflow (overflow),
    .fifoEmpty(fifoEmpty)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [DW-1:0] b, input int nbits, input int hi, input int lo);
    for (int i = DW - 1; i >= DW - nbits; i--) begin
      mosi = b[i];
      tick(lo);
      sck = 1'b1;
      last_rise_cyc = cyc;
      tick(hi);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [DW-1:0] b, input logic dc, input bit keep, input int hi, input int lo);
    dcIn = dc;
    if (keep) exp_q.push_back({dc, b});
    $display("tx byte=0x%02h dc=%0d expect_emit=%0d", b, dc, keep);
    send_bits(b, DW, hi, lo);
  endtask

  task automatic begin_frame();
    csN = 1'b0;
    tick(4);
  endtask

  task automatic end_frame();
    tick(3);
    csN = 1'b1;
    tick(4);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      tick(1);
      t++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    tick(PERIOD + 16);
  endtask

  task automatic wait_rises(input int target);
    int t;
    t = 0;
    while (n_rises < target && t < 5000) begin
      tick(1);
      t++;
    end
    check("rise_wait", n_rises >= target, 1);
  endtask

  // Monitor: pops the scoreboard on every dataEn rise and checks pulse shape
  initial begin : monitor
    logic          prev_en;
    int            width;
    int            low_cnt;
    bit            seen;
    logic [DW-1:0] held_d;
    logic          held_rs;
    logic [DW:0]   e;
    prev_en = 1'b0; width = 0; low_cnt = 0; seen = 1'b0; held_d = '0; held_rs = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_en = 1'b0; width = 0; seen = 1'b0; held_d = '0; held_rs = 1'b0;
      end else begin
        if (dataEn && !prev_en) begin
          n_rises++;
          if (seen) check("gap_len", low_cnt >= GAP, 1);
          check("pulse_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data", dataOut, e[DW-1:0]);
            check("rs", rs, e[DW]);
            $display("rx byte=0x%02h rs=%0d expected byte=0x%02h rs=%0d", dataOut, rs, e[DW-1:0], e[DW]);
          end
          if (lat_armed) begin
            check("latency_le6", (cyc - last_rise_cyc) <= 6, 1);
            lat_armed = 1'b0;
          end
          width = 1; held_d = dataOut; held_rs = rs; seen = 1'b1;
        end else if (dataEn) begin
          width++;
          check("stable_strobe", {rs, dataOut}, {held_rs, held_d});
        end else begin
          if (prev_en) begin
            check("pulse_width", width, EN);
            low_cnt = 1;
          end else begin
            low_cnt++;
          end
          check("stable_gap", {rs, dataOut}, {held_rs, held_d});
        end
        prev_en = dataEn;
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected finish before 95000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [DW-1:0] burst_b  [12];
    logic          burst_dc [12];
    int            nb;
    int            hi;
    int            lo;
    int            r0;
    logic [DW-1:0] b;
    logic          dc;

    burst_b  = '{8'h01, 8'h02, 8'h06, 8'h0C, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    burst_dc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    tick(2);
    check("rst_dataEn", dataEn, 0);
    check("rst_dataOut", dataOut, 0);
    check("rst_rs", rs, 0);
    check("rst_overflow", overflow, 0);
    check("rst_fifoEmpty", fifoEmpty, 1);
    reset = 1'b1;
    tick(4);

    // Single command byte with latency bound
    begin_frame();
    lat_armed = 1'b1;
    send_byte(8'h01, 1'b1, 1'b1, 3, 3);
    end_frame();
    drain("single");

    // Burst in chunks that never leave more than four bytes pending
    begin_frame();
    for (int i = 0; i < 12; i++) begin
      if (i == 5 || i == 10) begin
        end_frame();
        drain("burst_chunk");
        begin_frame();
      end
      send_byte(burst_b[i], burst_dc[i], 1'b1, 3, 3);
    end
    end_frame();
    drain("burst");
    check("burst_overflow", overflow, 0);

    // Aborted partial byte followed by a full 0xA5
    begin_frame();
    send_bits(8'($urandom), 5, 3, 3);
    end_frame();
    begin_frame();
    send_byte(8'hA5, 1'($urandom), 1'b1, 3, 3);
    end_frame();
    drain("abort");

    // Randomised groups with random aborts and random sck timing
    for (int g = 0; g < 8; g++) begin
      if ($urandom_range(0, 2) == 0) begin
        begin_frame();
        send_bits(8'($urandom), $urandom_range(1, 7), 3, 3);
        end_frame();
      end
      nb = $urandom_range(1, 5);
      begin_frame();
      for (int k = 0; k < nb; k++) begin
        hi = $urandom_range(3, 5);
        lo = $urandom_range(3, 5);
        send_byte(8'($urandom), 1'($urandom), 1'b1, hi, lo);
      end
      end_frame();
      drain("random");
    end
    check("random_overflow", overflow, 0);

    // Six back-to-back bytes inside one output period: sixth is dropped
    begin_frame();
    for (int i = 0; i < 6; i++) begin
      send_byte(8'($urandom), 1'($urandom), (i < 5), 3, 3);
    end
    end_frame();
    tick(2);
    check("ovf_set", overflow, 1);
    check("ovf_fifo_busy", fifoEmpty, 0);
    drain("overflow");
    check("ovf_sticky", overflow, 1);
    check("ovf_fifo_empty", fifoEmpty, 1);

    // Reset in the middle of a strobe with two bytes still queued
    r0 = n_rises;
    begin_frame();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom), 1'($urandom), 1'b1, 3, 3);
    end
    end_frame();
    wait_rises(r0 + 2);
    tick(3);
    reset = 1'b0;
    #1;
    check("midrst_dataEn", dataEn, 0);
    check("midrst_fifoEmpty", fifoEmpty, 1);
    check("midrst_overflow", overflow, 0);
    check("midrst_dataOut", dataOut, 0);
    exp_q.delete();
    tick(3);
    reset = 1'b1;
    r0 = n_rises;
    tick(2 * PERIOD);
    check("midrst_no_pulse", n_rises, r0);
    check("midrst_still_empty", fifoEmpty, 1);

    // Ten bytes one output period apart: pointers wrap twice
    for (int i = 0; i < 10; i++) begin
      b  = 8'($urandom);
      dc = 1'($urandom);
      begin_frame();
      lat_armed = 1'b1;
      send_byte(b, dc, 1'b1, 3, 3);
      end_frame();
      tick(PERIOD + 8);
    end
    drain("wrap");
    check("final_overflow", overflow, 0);
    check("final_fifoEmpty", fifoEmpty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
